// File: rtl/cache_arbiter.sv
// cache_arbiter: merges icache and dcache line traffic onto one physical-memory port.
// One transaction in flight at a time; address, write data and direction are latched
// at grant. Simultaneous requests alternate between the two caches.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   icache_pmem_read/_address     icache line-fill request (held until resp)
//   icache_pmem_rdata/_resp       fill data and one-cycle completion to icache
//   dcache_pmem_read/_write       dcache fill / writeback request (held until resp)
//   dcache_pmem_address/_wdata    dcache line address and writeback line
//   dcache_pmem_rdata/_resp       fill data and one-cycle completion to dcache
//   pmem_read/_write              memory request, held until pmem_resp
//   pmem_address/_wdata           latched transaction address and write line
//   pmem_rdata/_resp              memory read data and completion pulse
module cache_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  icache_pmem_read,
  input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
  output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
  output logic                  icache_pmem_resp,

  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
  input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   wdata_q;
  logic                    is_write_q;
  logic                    last_grant_q;  // 0 = icache, 1 = dcache

  logic i_req;
  logic d_req;
  logic grant_i;

  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

  // icache wins when it is alone, or on a tie when dcache was served last.
  assign grant_i = i_req & (~d_req | last_grant_q);

  // Arbitration state and latched transaction fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      is_write_q   <= 1'b0;
      last_grant_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q      <= SERVE_I;
            addr_q       <= icache_pmem_address;
            last_grant_q <= 1'b0;
          end else if (d_req) begin
            state_q      <= SERVE_D;
            addr_q       <= dcache_pmem_address;
            wdata_q      <= dcache_pmem_wdata;
            // read+write together is illegal; write takes precedence
            is_write_q   <= dcache_pmem_write;
            last_grant_q <= 1'b1;
          end
        end
        SERVE_I: begin
          if (pmem_resp) state_q <= IDLE;
        end
        SERVE_D: begin
          if (pmem_resp) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory request decode and response routing to the owning cache only.
  always_comb begin
    pmem_read         = 1'b0;
    pmem_write        = 1'b0;
    icache_pmem_resp  = 1'b0;
    dcache_pmem_resp  = 1'b0;
    icache_pmem_rdata = '0;
    dcache_pmem_rdata = '0;
    case (state_q)
      SERVE_I: begin
        pmem_read         = 1'b1;
        icache_pmem_resp  = pmem_resp;
        icache_pmem_rdata = pmem_rdata;
      end
      SERVE_D: begin
        pmem_read         = ~is_write_q;
        pmem_write        = is_write_q;
        dcache_pmem_resp  = pmem_resp;
        dcache_pmem_rdata = pmem_rdata;
      end
      default: ;
    endcase
  end

  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: a memory model answers pmem requests, the
// stimulus pushes expected memory transactions and cache responses, and a monitor
// pops and compares them as the DUT presents them.
module tb_cache_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic          clk;
  logic          rst;
  logic          icache_pmem_read;
  logic [AW-1:0] icache_pmem_address;
  logic [LW-1:0] icache_pmem_rdata;
  logic          icache_pmem_resp;
  logic          dcache_pmem_read;
  logic          dcache_pmem_write;
  logic [AW-1:0] dcache_pmem_address;
  logic [LW-1:0] dcache_pmem_wdata;
  logic [LW-1:0] dcache_pmem_rdata;
  logic          dcache_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  logic          mem_resp;
  logic          stray_resp;
  int            mem_lat;
  logic [LW-1:0] mem_data;

  assign pmem_resp = mem_resp | stray_resp;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    int            gap;   // required idle cycles before this transaction, -1 = unchecked
  } txn_t;

  typedef struct {
    logic          side;  // 0 = icache, 1 = dcache
    logic [LW-1:0] rdata;
  } rsp_t;

  txn_t txn_q[$];
  rsp_t rsp_q[$];

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  task automatic push_txn(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d, input int gap);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = d; t.gap = gap;
    txn_q.push_back(t);
  endtask

  task automatic push_rsp(input logic side, input logic [LW-1:0] d);
    rsp_t r;
    r.side = side; r.rdata = d;
    rsp_q.push_back(r);
  endtask

  // Wait (bounded) for a resp pulse on one side, then step just past the next edge.
  task automatic wait_resp(input logic side, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      if (side ? dcache_pmem_resp : icache_pmem_resp) seen = 1'b1;
    end
    if (!seen) chk("resp_timeout", LW'(0), LW'(1));
    @(posedge clk); #1;
  endtask

  // Memory model: respond mem_lat cycles after seeing a request.
  initial begin : mem_model
    int cnt;
    cnt = 0;
    mem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if ((pmem_read || pmem_write) && !mem_resp) begin
        if (cnt >= mem_lat) begin
          mem_resp = 1'b1;
          pmem_rdata = mem_data;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        mem_resp = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: checks memory-side transactions and cache responses against the queues.
  initial begin : monitor
    bit   active;
    bit   have;
    int   idle_run;
    txn_t cur;
    rsp_t r;
    active = 1'b0;
    have = 1'b0;
    idle_run = 0;
    forever begin
      @(negedge clk);
      if (pmem_read || pmem_write) begin
        if (!active) begin
          active = 1'b1;
          if (txn_q.size() == 0) begin
            have = 1'b0;
            chk("txn_unexpected", LW'(pmem_address), LW'(0));
          end else begin
            have = 1'b1;
            cur = txn_q.pop_front();
            if (cur.gap >= 0) chk("idle_gap", LW'(idle_run), LW'(cur.gap));
          end
        end
        if (have) begin
          chk("pmem_write", LW'(pmem_write), LW'(cur.wr));
          chk("pmem_read", LW'(pmem_read), LW'(!cur.wr));
          chk("pmem_address", LW'(pmem_address), LW'(cur.addr));
          if (cur.wr) chk("pmem_wdata", pmem_wdata, cur.wdata);
        end
        idle_run = 0;
      end else begin
        active = 1'b0;
        idle_run++;
      end
      if (icache_pmem_resp || dcache_pmem_resp) begin
        chk("resp_onehot", LW'(icache_pmem_resp & dcache_pmem_resp), LW'(0));
        if (rsp_q.size() == 0) begin
          chk("resp_unexpected", LW'({icache_pmem_resp, dcache_pmem_resp}), LW'(0));
        end else begin
          r = rsp_q.pop_front();
          chk("resp_side", LW'(dcache_pmem_resp), LW'(r.side));
          chk("resp_rdata", r.side ? dcache_pmem_rdata : icache_pmem_rdata, r.rdata);
          chk("other_rdata", r.side ? icache_pmem_rdata : dcache_pmem_rdata, LW'(0));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [LW-1:0] p_rst, p_a5, p_wb, wd, p_il, p_rr, p_st;
    p_rst = {8{32'hCAFE_0001}};
    p_a5  = {32{8'hA5}};
    p_wb  = {8{32'h0BAD_F00D}};
    wd    = {8{32'h1234_5678}};
    p_il  = {8{32'h5555_AAAA}};
    p_rr  = {8{32'h0F0F_7777}};
    p_st  = {8{32'hDEAD_BEEF}};

    stray_resp = 1'b0;
    mem_lat = 2;
    mem_data = p_rst;
    rst = 1'b0;
    icache_pmem_read = 1'b1;
    icache_pmem_address = 32'h0000_0040;
    dcache_pmem_read = 1'b1;
    dcache_pmem_write = 1'b0;
    dcache_pmem_address = 32'h0000_1000;
    dcache_pmem_wdata = '0;

    // Reset held with both caches requesting: everything quiet, then dcache first.
    push_txn(1'b0, 32'h0000_1000, '0, -1);
    push_rsp(1'b1, p_rst);
    push_txn(1'b0, 32'h0000_0040, '0, 1);
    push_rsp(1'b0, p_rst);
    repeat (3) begin
      @(negedge clk);
      chk("rst_pmem_read", LW'(pmem_read), LW'(0));
      chk("rst_pmem_write", LW'(pmem_write), LW'(0));
      chk("rst_i_resp", LW'(icache_pmem_resp), LW'(0));
      chk("rst_d_resp", LW'(dcache_pmem_resp), LW'(0));
      chk("rst_i_rdata", icache_pmem_rdata, LW'(0));
      chk("rst_d_rdata", dcache_pmem_rdata, LW'(0));
    end
    rst = 1'b1;
    wait_resp(1'b1, 20);
    dcache_pmem_read = 1'b0;
    wait_resp(1'b0, 20);
    icache_pmem_read = 1'b0;

    // dcache writeback; wdata/address change after grant must not leak out.
    repeat (2) @(posedge clk);
    #1;
    mem_lat = 3;
    mem_data = p_wb;
    push_txn(1'b1, 32'h0000_2000, wd, -1);
    push_rsp(1'b1, p_wb);
    dcache_pmem_write = 1'b1;
    dcache_pmem_address = 32'h0000_2000;
    dcache_pmem_wdata = wd;
    @(posedge clk);
    @(posedge clk); #1;
    dcache_pmem_wdata = ~wd;
    dcache_pmem_address = 32'h0000_2FE0;
    wait_resp(1'b1, 20);
    dcache_pmem_write = 1'b0;

    // dcache read and write together: handled as a write.
    repeat (2) @(posedge clk);
    #1;
    mem_lat = 1;
    mem_data = p_il;
    push_txn(1'b1, 32'h0000_3000, p_il, -1);
    push_rsp(1'b1, p_il);
    dcache_pmem_read = 1'b1;
    dcache_pmem_write = 1'b1;
    dcache_pmem_address = 32'h0000_3000;
    dcache_pmem_wdata = p_il;
    wait_resp(1'b1, 20);
    dcache_pmem_read = 1'b0;
    dcache_pmem_write = 1'b0;

    // icache solo with 5-cycle memory latency; request visible the cycle after.
    repeat (2) @(posedge clk);
    #1;
    mem_lat = 5;
    mem_data = p_a5;
    push_txn(1'b0, 32'h0000_0060, '0, -1);
    push_rsp(1'b0, p_a5);
    icache_pmem_read = 1'b1;
    icache_pmem_address = 32'h0000_0060;
    @(negedge clk);
    chk("lat_before_edge", LW'(pmem_read), LW'(0));
    @(negedge clk);
    chk("lat_after_edge", LW'(pmem_read), LW'(1));
    wait_resp(1'b0, 20);
    icache_pmem_read = 1'b0;

    // Round robin: icache served last, so continuous requests go D, I, D, I.
    repeat (2) @(posedge clk);
    #1;
    mem_lat = 1;
    mem_data = p_rr;
    push_txn(1'b0, 32'h0000_5000, '0, -1);
    push_rsp(1'b1, p_rr);
    push_txn(1'b0, 32'h0000_4000, '0, 1);
    push_rsp(1'b0, p_rr);
    push_txn(1'b0, 32'h0000_5000, '0, 1);
    push_rsp(1'b1, p_rr);
    push_txn(1'b0, 32'h0000_4000, '0, 1);
    push_rsp(1'b0, p_rr);
    icache_pmem_read = 1'b1;
    icache_pmem_address = 32'h0000_4000;
    dcache_pmem_read = 1'b1;
    dcache_pmem_address = 32'h0000_5000;
    wait_resp(1'b1, 20);
    wait_resp(1'b0, 20);
    wait_resp(1'b1, 20);
    wait_resp(1'b0, 20);
    icache_pmem_read = 1'b0;
    dcache_pmem_read = 1'b0;

    // Asynchronous reset two cycles into an icache transaction.
    repeat (2) @(posedge clk);
    #1;
    mem_lat = 10;
    push_txn(1'b0, 32'h0000_0080, '0, -1);
    icache_pmem_read = 1'b1;
    icache_pmem_address = 32'h0000_0080;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_read", LW'(pmem_read), LW'(0));
    chk("async_rst_i_resp", LW'(icache_pmem_resp), LW'(0));
    icache_pmem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_read", LW'(pmem_read), LW'(0));
      chk("post_rst_write", LW'(pmem_write), LW'(0));
    end

    // Stray pmem_resp in IDLE: no cache resp, arbiter stays idle and usable.
    @(posedge clk); #1;
    stray_resp = 1'b1;
    @(negedge clk);
    chk("stray_i_resp", LW'(icache_pmem_resp), LW'(0));
    chk("stray_d_resp", LW'(dcache_pmem_resp), LW'(0));
    @(posedge clk); #1;
    stray_resp = 1'b0;
    @(negedge clk);
    chk("stray_idle", LW'(pmem_read | pmem_write), LW'(0));
    @(posedge clk); #1;
    mem_lat = 1;
    mem_data = p_st;
    push_txn(1'b0, 32'h0000_0090, '0, -1);
    push_rsp(1'b0, p_st);
    icache_pmem_read = 1'b1;
    icache_pmem_address = 32'h0000_0090;
    @(negedge clk);
    chk("stray_lat_before", LW'(pmem_read), LW'(0));
    @(negedge clk);
    chk("stray_lat_after", LW'(pmem_read), LW'(1));
    wait_resp(1'b0, 20);
    icache_pmem_read = 1'b0;

    repeat (3) @(negedge clk);
    chk("txn_q_drained", LW'(txn_q.size()), LW'(0));
    chk("rsp_q_drained", LW'(rsp_q.size()), LW'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
